// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: pipeline bus record types shared by EX, MEM and WB.
//   es_to_ms_bus_t   : EX -> MEM instruction record
//   ms_to_ws_bus_t   : MEM -> WB completed record
//   ms_forward_bus_t : MEM -> ID forwarding/stall information
package cpu_defs_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;

  localparam logic [1:0] C0_NONE = 2'd0;
  localparam logic [1:0] C0_MFC0 = 2'd1;
  localparam logic [1:0] C0_MTC0 = 2'd2;
  localparam logic [1:0] C0_ERET = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [4:0]  excode;
    logic        bd;
    logic [31:0] badvaddr;
  } exc_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic [2:0]  load_op;
    logic        mem_req;
    logic [1:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [1:0]  tlb_op;
    exc_t        exception;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic [1:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [1:0]  tlb_op;
    exc_t        exception;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        data_pending;
    logic        op_mfc0;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_forward_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles every bus the MEM stage talks over.
//   EX side   : es_to_ms_bus (in), ms_allowin (out)
//   WB side   : ms_to_ws_bus (out), ws_allowin (in), flush (in)
//   SRAM resp : data_sram_data_ok, data_sram_rdata (in)
//   ID side   : ms_forward_bus (out)
// master = the MEM stage itself, slave = its surroundings.
interface mem_stage_if;
  cpu_defs_pkg::es_to_ms_bus_t   es_to_ms_bus;
  logic                          ms_allowin;
  logic                          ws_allowin;
  logic                          flush;
  logic                          data_sram_data_ok;
  logic [31:0]                   data_sram_rdata;
  cpu_defs_pkg::ms_to_ws_bus_t   ms_to_ws_bus;
  cpu_defs_pkg::ms_forward_bus_t ms_forward_bus;

  modport master (
    input  es_to_ms_bus, ws_allowin, flush, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_bus, ms_forward_bus
  );

  modport slave (
    output es_to_ms_bus, ws_allowin, flush, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_bus, ms_forward_bus
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Holds one instruction, waits for its data-SRAM response, aligns and
// extends load data, and hands the record to WB on valid/allowin.
// Responses belonging to flushed instructions are counted and dropped.
// Ports: clk, resetn (async active-low), bus (mem_stage_if.master).
module mem_stage
  import cpu_defs_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  mem_stage_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  // Latched instruction, minus the fields only needed at latch time.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic [2:0]  load_op;
    logic [1:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [1:0]  tlb_op;
    exc_t        exception;
  } ms_rec_t;

  state_e      state_q, state_d;
  logic        ms_valid_q, ms_valid_d;
  ms_rec_t     rec_q, rec_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  cancel_cnt_q, cancel_cnt_d;

  logic        resp_ok, ready_go, allowin, latch, inc, dec;
  logic [31:0] aligned, final_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // A response only belongs to the held instruction once all stale
    // responses of flushed instructions have drained.
    resp_ok  = bus.data_sram_data_ok && (cancel_cnt_q == 2'd0);
    ready_go = (state_q == S_IDLE) || (state_q == S_WAIT && resp_ok) ||
               (state_q == S_HOLD);
    allowin  = !ms_valid_q || (ready_go && bus.ws_allowin);
    latch    = bus.es_to_ms_bus.valid && allowin && !bus.flush;

    ld_byte = bus.data_sram_rdata[8*rec_q.result[1:0] +: 8];
    ld_half = rec_q.result[1] ? bus.data_sram_rdata[31:16]
                              : bus.data_sram_rdata[15:0];
    case (rec_q.load_op)
      LD_LB:   aligned = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  aligned = {24'd0, ld_byte};
      LD_LH:   aligned = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  aligned = {16'd0, ld_half};
      LD_LW:   aligned = bus.data_sram_rdata;
      default: aligned = rec_q.result;
    endcase

    // Only WAIT has live rdata; HOLD replays the captured value, IDLE
    // (ALU ops and exception records) passes the EX result through.
    case (state_q)
      S_WAIT:  final_result = aligned;
      S_HOLD:  final_result = buf_q;
      default: final_result = rec_q.result;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (resp_ok) state_d = bus.ws_allowin ? S_IDLE : S_HOLD;
      S_HOLD:  if (bus.ws_allowin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A latch only happens once the current instruction is leaving.
    if (latch)
      state_d = (bus.es_to_ms_bus.mem_req && !bus.es_to_ms_bus.exception.valid)
                ? S_WAIT : S_IDLE;
    if (bus.flush) state_d = S_IDLE;

    ms_valid_d = ms_valid_q;
    if (bus.flush)    ms_valid_d = 1'b0;
    else if (allowin) ms_valid_d = bus.es_to_ms_bus.valid;

    rec_d = rec_q;
    if (latch) begin
      rec_d.pc        = bus.es_to_ms_bus.pc;
      rec_d.dest      = bus.es_to_ms_bus.dest;
      rec_d.rf_we     = bus.es_to_ms_bus.rf_we;
      rec_d.result    = bus.es_to_ms_bus.result;
      rec_d.load_op   = bus.es_to_ms_bus.load_op;
      rec_d.c0_op     = bus.es_to_ms_bus.c0_op;
      rec_d.c0_addr   = bus.es_to_ms_bus.c0_addr;
      rec_d.tlb_op    = bus.es_to_ms_bus.tlb_op;
      rec_d.exception = bus.es_to_ms_bus.exception;
    end

    buf_d = buf_q;
    if (state_q == S_WAIT && resp_ok && !bus.ws_allowin && !bus.flush)
      buf_d = aligned;

    // Flushing a WAIT whose own response has not arrived leaves one
    // response in flight that must be swallowed later.
    inc = bus.flush && (state_q == S_WAIT) && !resp_ok;
    dec = bus.data_sram_data_ok && (cancel_cnt_q != 2'd0);
    cancel_cnt_d = cancel_cnt_q;
    if (inc && !dec && cancel_cnt_q != 2'd3) cancel_cnt_d = cancel_cnt_q + 2'd1;
    else if (dec && !inc)                    cancel_cnt_d = cancel_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ms_valid_q   <= 1'b0;
      rec_q        <= '0;
      buf_q        <= '0;
      cancel_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      ms_valid_q   <= ms_valid_d;
      rec_q        <= rec_d;
      buf_q        <= buf_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  always_comb begin
    bus.ms_allowin                = allowin;
    bus.ms_to_ws_bus.valid        = ms_valid_q && ready_go && !bus.flush;
    bus.ms_to_ws_bus.pc           = rec_q.pc;
    bus.ms_to_ws_bus.dest         = rec_q.dest;
    bus.ms_to_ws_bus.rf_we        = rec_q.rf_we;
    bus.ms_to_ws_bus.result       = final_result;
    bus.ms_to_ws_bus.c0_op        = rec_q.c0_op;
    bus.ms_to_ws_bus.c0_addr      = rec_q.c0_addr;
    bus.ms_to_ws_bus.tlb_op       = rec_q.tlb_op;
    bus.ms_to_ws_bus.exception    = rec_q.exception;

    bus.ms_forward_bus.data_pending = ms_valid_q && (rec_q.load_op != LD_NONE) && !ready_go;
    bus.ms_forward_bus.op_mfc0      = ms_valid_q && (rec_q.c0_op == C0_MFC0);
    bus.ms_forward_bus.rf_we        = rec_q.rf_we;
    bus.ms_forward_bus.dest         = ms_valid_q ? rec_q.dest : 5'd0;
    bus.ms_forward_bus.result       = final_result;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
module tb_mem_stage;
  import cpu_defs_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage u_dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_out    = 0;
  ms_to_ws_bus_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic es_to_ms_bus_t mk(input logic [31:0] pc, input logic [4:0] dest,
                                       input logic [2:0] lop, input logic mreq,
                                       input logic [31:0] res);
    es_to_ms_bus_t r;
    r = '0;
    r.valid   = 1'b1;
    r.pc      = pc;
    r.dest    = dest;
    r.rf_we   = 4'hf;
    r.result  = res;
    r.load_op = lop;
    r.mem_req = mreq;
    r.c0_addr = {3'd0, dest};
    return r;
  endfunction

  task automatic push(input es_to_ms_bus_t e, input logic [31:0] res);
    ms_to_ws_bus_t m;
    m = '0;
    m.valid     = 1'b1;
    m.pc        = e.pc;
    m.dest      = e.dest;
    m.rf_we     = e.rf_we;
    m.result    = res;
    m.c0_op     = e.c0_op;
    m.c0_addr   = e.c0_addr;
    m.tlb_op    = e.tlb_op;
    m.exception = e.exception;
    exp_q.push_back(m);
    n_push++;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // WB-side monitor: every accepted record is popped and compared.
  always @(negedge clk) begin
    if (resetn && bus.ms_to_ws_bus.valid && bus.ws_allowin) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        ms_to_ws_bus_t e;
        e = exp_q.pop_front();
        chk("out_result", 64'(bus.ms_to_ws_bus.result), 64'(e.result));
        chk("out_pc",     64'(bus.ms_to_ws_bus.pc),     64'(e.pc));
        chk("out_dest",   64'(bus.ms_to_ws_bus.dest),   64'(e.dest));
        chk("out_rf_we",  64'(bus.ms_to_ws_bus.rf_we),  64'(e.rf_we));
        chk("out_c0",     64'({bus.ms_to_ws_bus.c0_op, bus.ms_to_ws_bus.c0_addr, bus.ms_to_ws_bus.tlb_op}),
                          64'({e.c0_op, e.c0_addr, e.tlb_op}));
        chk("out_exc",    64'(bus.ms_to_ws_bus.exception), 64'(e.exception));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    es_to_ms_bus_t e;
    resetn = 1'b0;
    bus.es_to_ms_bus      = '0;
    bus.ws_allowin        = 1'b1;
    bus.flush             = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = '0;

    // reset state
    mid();
    chk("rst_allowin", 64'(bus.ms_allowin), 64'd1);
    chk("rst_valid",   64'(bus.ms_to_ws_bus.valid), 64'd0);
    chk("rst_fwd",     64'(bus.ms_forward_bus), 64'd0);
    nxt(); resetn = 1'b1;
    nxt();

    // LB sign extend, a=3
    e = mk(32'h100, 5'd5, LD_LB, 1'b1, 32'h1003);
    bus.es_to_ms_bus = e; push(e, 32'hFFFF_FF80);
    nxt();
    bus.es_to_ms_bus = '0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h80FF_1234;
    mid();
    chk("lb_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    chk("lb_fwd_dest", 64'(bus.ms_forward_bus.dest), 64'd5);
    nxt();
    bus.data_sram_data_ok = 1'b0;
    mid();
    chk("lb_one_cycle", 64'(bus.ms_to_ws_bus.valid), 64'd0);
    chk("idle_fwd_dest", 64'(bus.ms_forward_bus.dest), 64'd0);

    // LHU / LW / ALU back-to-back
    nxt();
    e = mk(32'h200, 5'd6, LD_LHU, 1'b1, 32'h2002);
    bus.es_to_ms_bus = e; push(e, 32'h0000_9ABC);
    nxt();
    e = mk(32'h204, 5'd7, LD_LW, 1'b1, 32'h2004);
    bus.es_to_ms_bus = e; push(e, 32'h1122_3344);
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h9ABC_0000;
    mid();
    chk("b2b_allowin_lhu", 64'(bus.ms_allowin), 64'd1);
    nxt();
    e = mk(32'h208, 5'd8, LD_NONE, 1'b0, 32'h55);
    bus.es_to_ms_bus = e; push(e, 32'h55);
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h1122_3344;
    mid();
    chk("b2b_allowin_lw", 64'(bus.ms_allowin), 64'd1);
    nxt();
    bus.es_to_ms_bus = '0; bus.data_sram_data_ok = 1'b0;
    mid();
    chk("alu_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    nxt();

    // late data_ok (3 cycles of wait)
    e = mk(32'h300, 5'd9, LD_LW, 1'b1, 32'h3000);
    bus.es_to_ms_bus = e; push(e, 32'hCAFE_F00D);
    nxt();
    bus.es_to_ms_bus = '0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("late_pending", 64'(bus.ms_forward_bus.data_pending), 64'd1);
      chk("late_allowin", 64'(bus.ms_allowin), 64'd0);
      nxt();
    end
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hCAFE_F00D;
    mid();
    chk("late_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    nxt();
    bus.data_sram_data_ok = 1'b0;

    // HOLD under WB stall, rdata changes afterward
    e = mk(32'h400, 5'd10, LD_LW, 1'b1, 32'h4000);
    bus.es_to_ms_bus = e; push(e, 32'hA5A5_0001);
    nxt();
    bus.es_to_ms_bus = '0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hA5A5_0001;
    bus.ws_allowin = 1'b0;
    mid();
    chk("hold_allowin0", 64'(bus.ms_allowin), 64'd0);
    nxt();
    bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'hBAD0_BAD0;
    mid();
    chk("hold_allowin1", 64'(bus.ms_allowin), 64'd0);
    chk("hold_pending",  64'(bus.ms_forward_bus.data_pending), 64'd0);
    nxt();
    bus.ws_allowin = 1'b1;
    mid();
    chk("hold_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    nxt();

    // flush in WAIT, stale response dropped
    e = mk(32'h500, 5'd11, LD_LW, 1'b1, 32'h5000);
    bus.es_to_ms_bus = e;
    nxt();
    bus.es_to_ms_bus = '0; bus.flush = 1'b1;
    mid();
    chk("flush_no_out", 64'(bus.ms_to_ws_bus.valid), 64'd0);
    nxt();
    bus.flush = 1'b0;
    e = mk(32'h504, 5'd12, LD_LW, 1'b1, 32'h5004);
    bus.es_to_ms_bus = e; push(e, 32'h0000_1234);
    nxt();
    bus.es_to_ms_bus = '0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h0000_DEAD;
    mid();
    chk("stale_ignored", 64'(bus.ms_to_ws_bus.valid), 64'd0);
    chk("stale_pending", 64'(bus.ms_forward_bus.data_pending), 64'd1);
    nxt();
    bus.data_sram_rdata = 32'h0000_1234;
    mid();
    chk("after_stale_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    nxt();
    bus.data_sram_data_ok = 1'b0;

    // flush together with data_ok: no cancel recorded
    e = mk(32'h600, 5'd13, LD_LW, 1'b1, 32'h6000);
    bus.es_to_ms_bus = e;
    nxt();
    bus.es_to_ms_bus = '0; bus.flush = 1'b1;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h0000_0999;
    mid();
    chk("flush_ok_no_out", 64'(bus.ms_to_ws_bus.valid), 64'd0);
    nxt();
    bus.flush = 1'b0; bus.data_sram_data_ok = 1'b0;
    e = mk(32'h604, 5'd14, LD_LW, 1'b1, 32'h6004);
    bus.es_to_ms_bus = e; push(e, 32'h77);
    nxt();
    bus.es_to_ms_bus = '0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h77;
    mid();
    chk("flush_ok_next_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    nxt();
    bus.data_sram_data_ok = 1'b0;

    // exception pass-through
    e = mk(32'h700, 5'd15, LD_LW, 1'b0, 32'h7001);
    e.exception.valid    = 1'b1;
    e.exception.excode   = 5'h04;
    e.exception.badvaddr = 32'h7001;
    bus.es_to_ms_bus = e; push(e, 32'h7001);
    nxt();
    bus.es_to_ms_bus = '0;
    mid();
    chk("exc_valid",   64'(bus.ms_to_ws_bus.valid), 64'd1);
    chk("exc_pending", 64'(bus.ms_forward_bus.data_pending), 64'd0);
    nxt();

    // asynchronous reset during WAIT
    e = mk(32'h800, 5'd16, LD_LW, 1'b1, 32'h8000);
    bus.es_to_ms_bus = e;
    nxt();
    bus.es_to_ms_bus = '0;
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_allowin", 64'(bus.ms_allowin), 64'd1);
    chk("rstmid_valid",   64'(bus.ms_to_ws_bus.valid), 64'd0);
    chk("rstmid_fwd",     64'(bus.ms_forward_bus), 64'd0);
    nxt();
    resetn = 1'b1;
    nxt();
    e = mk(32'h810, 5'd17, LD_LW, 1'b1, 32'h8100);
    bus.es_to_ms_bus = e; push(e, 32'h4242);
    nxt();
    bus.es_to_ms_bus = '0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h4242;
    mid();
    chk("post_rst_valid", 64'(bus.ms_to_ws_bus.valid), 64'd1);
    nxt();
    bus.data_sram_data_ok = 1'b0;
    nxt();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("delivery_count",   64'(n_out), 64'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
